// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver exposing one read-only data/status word on the
// mem_* slave bus. Holds the last received byte plus valid, overrun and framing flags.
module uart_receiver #(
    parameter int CLK_DIVIDER_BIT = 173
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    input  logic        uart_rx
);

    localparam int CNT_W = $clog2(CLK_DIVIDER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIVIDER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLK_DIVIDER_BIT / 2 - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             rx_meta;
    logic             rxs;

    logic [7:0]       data;
    logic             valid;
    logic             overrun;
    logic             frame_err;

    logic             rd_req;
    logic             at_bit_end;
    logic             byte_done;
    logic             frame_bad;
    logic             unused_bus;

    // Address, write data and the fetch flag carry no meaning for this register.
    assign unused_bus = ^{mem_instr, mem_addr, mem_wdata};

    assign rd_req     = mem_valid && (mem_wstrb == 4'b0000);
    assign at_bit_end = (cnt == CNT_LAST);
    assign byte_done  = (state == STOP) && at_bit_end && rxs;
    assign frame_bad  = (state == STOP) && at_bit_end && !rxs;

    // Two-flop synchroniser followed by the bit-timing state machine. The start bit is
    // re-checked at its middle, after which every sample lands mid-bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        if (!rxs) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (at_bit_end) begin
                        shreg   <= {rxs, shreg[7:1]};
                        cnt     <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop-bit gives half a bit of slack for the next start edge.
                    if (at_bit_end) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Bus response and flag bookkeeping. A completing frame wins over a same-cycle read
    // clear, and the read itself still returns the contents from before the update.
    // The byte field reads as zero whenever no unread byte is held.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
            data      <= 8'h00;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            mem_ready <= mem_valid;
            mem_rdata <= rd_req ? {21'd0, frame_err, overrun, valid, (valid ? data : 8'h00)}
                                : 32'd0;

            if (byte_done) begin
                data  <= shreg;
                valid <= 1'b1;
            end else if (rd_req) begin
                valid <= 1'b0;
            end

            if (byte_done && valid && !rd_req) begin
                overrun <= 1'b1;
            end else if (rd_req) begin
                overrun <= 1'b0;
            end

            if (frame_bad) begin
                frame_err <= 1'b1;
            end else if (rd_req) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: drives serial frames and bus accesses into uart_receiver and compares
// every bus response with a byte/flag model of the receive register.
module tb_uart_receiver;

    localparam int DIV = 173;
    localparam int MID = DIV / 2 - 1;
    // Posedge (counting the first one after the start-bit edge as 1) on which the stop
    // bit is judged: 2 sync flops, 1 idle detect, MID+1 start half-bit, then 9 full bits.
    localparam int STOP_ACCEPT_EDGE = 4 + MID + 9 * DIV;

    logic        clock;
    logic        reset;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        uart_rx;

    int vectors;
    int miscompares;

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_over;
    logic       m_ferr;

    uart_receiver #(.CLK_DIVIDER_BIT(DIV)) dut (
        .clock     (clock),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .uart_rx   (uart_rx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference register: one held byte, newest wins, flags cleared by any read.
    task automatic model_reset();
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_over  = 1'b0;
        m_ferr  = 1'b0;
    endtask

    task automatic model_read(output logic [31:0] word);
        word    = {21'd0, m_ferr, m_over, m_valid, (m_valid ? m_data : 8'h00)};
        m_valid = 1'b0;
        m_over  = 1'b0;
        m_ferr  = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] value, input logic stop_bit);
        if (stop_bit) begin
            if (m_valid) m_over = 1'b1;
            m_data  = value;
            m_valid = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    // Serialises start, 8 data bits LSB first and stop, each DIV clocks long. A zero stop
    // bit is released early so its tail cannot be mistaken for a new start bit.
    task automatic applyStimulus(input logic [7:0] value, input logic stop_bit, input int nbits);
        logic [9:0] frame;
        frame = {stop_bit, value, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock);
            uart_rx = frame[i];
            if (i == 9 && !frame[i]) begin
                repeat (DIV / 2 + 8) @(negedge clock);
                uart_rx = 1'b1;
                repeat (DIV - DIV / 2 - 9) @(negedge clock);
            end else begin
                repeat (DIV - 1) @(negedge clock);
            end
        end
        if (nbits == 10) model_frame(value, stop_bit);
    endtask

    task automatic bus_access(input string tag, input logic is_write);
        logic [31:0] expected;
        expected = 32'd0;
        if (!is_write) model_read(expected);
        @(negedge clock);
        mem_valid = 1'b1;
        mem_instr = 1'($urandom_range(0, 1));
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_wstrb = is_write ? 4'($urandom_range(1, 15)) : 4'b0000;
        @(negedge clock);
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
        checkOutput({tag, "_ready"}, {31'd0, mem_ready}, 32'd1);
        checkOutput(tag, mem_rdata, expected);
        @(negedge clock);
        checkOutput({tag, "_ready_drop"}, {31'd0, mem_ready}, 32'd0);
        checkOutput({tag, "_rdata_idle"}, mem_rdata, 32'd0);
    endtask

    // Write immediately followed by a read, with mem_valid held high across both.
    task automatic bus_write_then_read(input string tag);
        logic [31:0] expected;
        @(negedge clock);
        mem_valid = 1'b1;
        mem_wstrb = 4'($urandom_range(1, 15));
        mem_wdata = $urandom;
        @(negedge clock);
        mem_wstrb = 4'b0000;
        checkOutput({tag, "_wr_ready"}, {31'd0, mem_ready}, 32'd1);
        checkOutput({tag, "_wr_rdata"}, mem_rdata, 32'd0);
        model_read(expected);
        @(negedge clock);
        mem_valid = 1'b0;
        checkOutput({tag, "_rd_ready"}, {31'd0, mem_ready}, 32'd1);
        checkOutput({tag, "_rd_rdata"}, mem_rdata, expected);
        @(negedge clock);
        checkOutput({tag, "_ready_drop"}, {31'd0, mem_ready}, 32'd0);
    endtask

    // Runs a frame while a read lands on exactly the cycle its stop bit is judged.
    task automatic frame_with_coincident_read(input string tag, input logic [7:0] value,
                                              input logic stop_bit);
        fork
            applyStimulus(value, stop_bit, 10);
            begin
                @(negedge clock);
                repeat (STOP_ACCEPT_EDGE - 2) @(negedge clock);
                bus_access(tag, 1'b0);
            end
        join
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_reset();
        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'b0000;
        uart_rx   = 1'b1;

        repeat (3) @(negedge clock);
        checkOutput("reset_ready", {31'd0, mem_ready}, 32'd0);
        checkOutput("reset_rdata", mem_rdata, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        bus_access("idle_read", 1'b0);

        applyStimulus(8'hA5, 1'b1, 10);
        bus_access("a5_read", 1'b0);
        bus_access("a5_reread", 1'b0);

        applyStimulus(8'h3C, 1'b1, 10);
        applyStimulus(8'h7E, 1'b1, 10);
        bus_access("overrun_read", 1'b0);
        bus_access("overrun_reread", 1'b0);

        applyStimulus(8'h55, 1'b0, 10);
        bus_access("frame_err_read", 1'b0);
        bus_access("frame_err_reread", 1'b0);

        @(negedge clock);
        uart_rx = 1'b0;
        repeat (40) @(negedge clock);
        uart_rx = 1'b1;
        repeat (200) @(negedge clock);
        bus_access("glitch_read", 1'b0);
        applyStimulus(8'h12, 1'b1, 10);
        bus_access("after_glitch_read", 1'b0);

        frame_with_coincident_read("coincide_empty", 8'h81, 1'b1);
        bus_access("coincide_empty_next", 1'b0);

        applyStimulus(8'h44, 1'b1, 10);
        frame_with_coincident_read("coincide_full", 8'h99, 1'b1);
        bus_access("coincide_full_next", 1'b0);

        frame_with_coincident_read("coincide_ferr", 8'h6D, 1'b0);
        bus_access("coincide_ferr_next", 1'b0);

        applyStimulus(8'h5A, 1'b1, 10);
        bus_access("write_ack", 1'b1);
        bus_write_then_read("b2b");

        applyStimulus(8'h66, 1'b1, 10);
        applyStimulus(8'hC3, 1'b1, 4);
        @(negedge clock);
        reset   = 1'b1;
        uart_rx = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        repeat (2 * DIV) @(negedge clock);
        bus_access("after_reset_read", 1'b0);
        applyStimulus(8'h0F, 1'b1, 10);
        bus_access("after_reset_frame", 1'b0);

        for (int n = 0; n < 16; n++) begin
            applyStimulus(8'($urandom_range(0, 255)), 1'($urandom_range(0, 5) != 0), 10);
            case ($urandom_range(0, 2))
                0: ;
                1: bus_access("rand_read", 1'b0);
                default: begin
                    bus_access("rand_write", 1'b1);
                    bus_access("rand_read_after_write", 1'b0);
                end
            endcase
            repeat ($urandom_range(0, 50)) @(negedge clock);
        end
        bus_access("final_read", 1'b0);
        bus_access("final_reread", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
